// File: rtl/mem_arbiter.sv
// Arbitrates the single-port RAM between instruction fetch and the data port.
// Each access takes WAIT RAM cycles plus one ready cycle; also holds the LL/SC link bit.
module mem_arbiter #(
    parameter int unsigned WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_ce,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_ready,

    input  logic        dm_ce,
    input  logic        dm_wr,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,

    output logic        ram_ce,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,

    input  logic        wbit,
    input  logic        wLLbit,
    input  logic        flush,
    output logic        rLLbit,

    output logic        stall
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    localparam logic [3:0] CntLoad = 4'(WAIT - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        grant_dm_q;
    logic        last_dm_q;
    logic        wr_q;
    logic        llbit_q;
    logic        pick_dm;

    // On a tie the port that did not win last time is served.
    always_comb begin
        pick_dm = dm_ce;
        if (dm_ce && if_ce) begin
            pick_dm = ~last_dm_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            grant_dm_q <= 1'b0;
            last_dm_q  <= 1'b0;
            wr_q       <= 1'b0;
            ram_ce     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= 32'd0;
            ram_wdata  <= 32'd0;
            if_data    <= 32'd0;
            if_ready   <= 1'b0;
            dm_rdata   <= 32'd0;
            dm_ready   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (dm_ce || if_ce) begin
                        grant_dm_q <= pick_dm;
                        wr_q       <= pick_dm & dm_wr;
                        cnt_q      <= CntLoad;
                        ram_ce     <= 1'b1;
                        ram_we     <= pick_dm & dm_wr;
                        ram_addr   <= pick_dm ? dm_addr : if_addr;
                        ram_wdata  <= pick_dm ? dm_wdata : 32'd0;
                        state_q    <= StAccess;
                    end
                end
                StAccess: begin
                    if (cnt_q == 4'd0) begin
                        ram_ce  <= 1'b0;
                        ram_we  <= 1'b0;
                        state_q <= StDone;
                        if (grant_dm_q) begin
                            dm_ready <= 1'b1;
                            dm_rdata <= wr_q ? 32'd0 : ram_rdata;
                        end else begin
                            if_ready <= 1'b1;
                            if_data  <= ram_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    if_ready  <= 1'b0;
                    dm_ready  <= 1'b0;
                    last_dm_q <= grant_dm_q;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // A data-side instruction commits when it has no access or its access completes now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            llbit_q <= 1'b0;
        end else if (flush) begin
            llbit_q <= 1'b0;
        end else if (wbit && (!dm_ce || dm_ready)) begin
            llbit_q <= wLLbit;
        end
    end

    assign rLLbit = llbit_q;
    assign stall  = (dm_ce & ~dm_ready) | (if_ce & ~if_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: scoreboard of expected completions checked by a monitor,
// plus per-scenario tasks with inline timing and protocol checks.
module tb_mem_arbiter;
    localparam int Wait = 2;

    typedef struct {
        logic        is_dm;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t sb1[$];
    exp_t mon_e;
    logic [31:0] ref_mem [logic [31:0]];

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        if_ce = 1'b0, dm_ce = 1'b0, dm_wr = 1'b0;
    logic [31:0] if_addr = 32'd0, dm_addr = 32'd0, dm_wdata = 32'd0;
    logic        wbit = 1'b0, wLLbit = 1'b0, flush = 1'b0;
    logic [31:0] if_data, dm_rdata, ram_addr, ram_wdata, ram_rdata;
    logic        if_ready, dm_ready, ram_ce, ram_we, rLLbit, stall;

    logic        w1_if_ce = 1'b0;
    logic [31:0] w1_if_addr = 32'd0;
    logic [31:0] w1_if_data, w1_dm_rdata, w1_ram_addr, w1_ram_wdata, w1_ram_rdata;
    logic        w1_if_ready, w1_dm_ready, w1_ram_ce, w1_ram_we, w1_rLLbit, w1_stall;

    logic [31:0]  mem [0:255];
    logic [255:0] wrote;

    always #5 clk = ~clk;

    function automatic logic [31:0] base_val(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {16'hC0DE, a[15:0] ^ 16'h5A5A};
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return base_val(a);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            wrote <= '0;
        end else if (ram_ce && ram_we) begin
            mem[ram_addr[9:2]]   <= ram_wdata;
            wrote[ram_addr[9:2]] <= 1'b1;
        end
    end

    assign ram_rdata = !ram_ce ? 32'd0 :
                       (wrote[ram_addr[9:2]] ? mem[ram_addr[9:2]] : base_val(ram_addr));
    assign w1_ram_rdata = w1_ram_ce ? base_val(w1_ram_addr) : 32'd0;

    mem_arbiter #(.WAIT(Wait)) dut (
        .clk(clk), .rst(rst),
        .if_ce(if_ce), .if_addr(if_addr), .if_data(if_data), .if_ready(if_ready),
        .dm_ce(dm_ce), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .wbit(wbit), .wLLbit(wLLbit), .flush(flush), .rLLbit(rLLbit), .stall(stall)
    );

    mem_arbiter #(.WAIT(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_ce(w1_if_ce), .if_addr(w1_if_addr), .if_data(w1_if_data), .if_ready(w1_if_ready),
        .dm_ce(1'b0), .dm_wr(1'b0), .dm_addr(32'd0), .dm_wdata(32'd0),
        .dm_rdata(w1_dm_rdata), .dm_ready(w1_dm_ready),
        .ram_ce(w1_ram_ce), .ram_we(w1_ram_we), .ram_addr(w1_ram_addr),
        .ram_wdata(w1_ram_wdata), .ram_rdata(w1_ram_rdata),
        .wbit(1'b0), .wLLbit(1'b0), .flush(1'b0), .rLLbit(w1_rLLbit), .stall(w1_stall)
    );

    // Scoreboard monitor for the WAIT=2 instance.
    always @(negedge clk) begin
        if (if_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL if_unexpected: if_ready=1 data=%h, no completion expected", if_data);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_dm !== 1'b0 || if_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL if_result: got port=fetch data=%h, expected port=%s data=%h",
                             if_data, mon_e.is_dm ? "data" : "fetch", mon_e.data);
                end
            end
        end
        if (dm_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL dm_unexpected: dm_ready=1 data=%h, no completion expected", dm_rdata);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_dm !== 1'b1 || dm_rdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL dm_result: got port=data data=%h, expected port=%s data=%h",
                             dm_rdata, mon_e.is_dm ? "data" : "fetch", mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ram_ce, ram_we, if_ready, dm_ready, rLLbit} !== 5'b0 || ram_addr !== 32'd0 ||
            ram_wdata !== 32'd0 || if_data !== 32'd0 || dm_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: ce=%b we=%b ifr=%b dmr=%b ll=%b addr=%h wd=%h ifd=%h dmd=%h, expected all 0",
                     ram_ce, ram_we, if_ready, dm_ready, rLLbit, ram_addr, ram_wdata, if_data, dm_rdata);
        end
        checks++;
        if ({w1_ram_ce, w1_ram_we, w1_if_ready, w1_dm_ready, w1_rLLbit, w1_stall} !== 6'b0 ||
            w1_ram_addr !== 32'd0 || w1_ram_wdata !== 32'd0 || w1_if_data !== 32'd0 ||
            w1_dm_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs_w1: ce=%b ifr=%b dmr=%b ifd=%h dmd=%h, expected all 0",
                     w1_ram_ce, w1_if_ready, w1_dm_ready, w1_if_data, w1_dm_rdata);
        end
        dm_ce = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall_comb: stall=%b with dm_ce=1, expected 1", stall);
        end
        dm_ce = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall_idle: stall=%b with no request, expected 0", stall);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        tick();
        if_ce   = 1'b1;
        if_addr = 32'h100;
        sb.push_back('{1'b0, 32'hDEADBEEF});
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || ram_ce !== 1'b0) begin
            errors++;
            $display("FAIL fetch_cycle0: stall=%b ram_ce=%b, expected 1 0", stall, ram_ce);
        end
        for (int c = 1; c <= Wait; c++) begin
            @(negedge clk);
            checks++;
            if (ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'h100 ||
                stall !== 1'b1 || if_ready !== 1'b0) begin
                errors++;
                $display("FAIL fetch_access c%0d: ce=%b we=%b addr=%h stall=%b rdy=%b, expected 1 0 00000100 1 0",
                         c, ram_ce, ram_we, ram_addr, stall, if_ready);
            end
        end
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b1 || ram_ce !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL fetch_done: if_ready=%b ram_ce=%b stall=%b, expected 1 0 0",
                     if_ready, ram_ce, stall);
        end
        tick();
        if_ce = 1'b0;
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b0 || if_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fetch_hold: if_ready=%b if_data=%h, expected 0 deadbeef", if_ready, if_data);
        end
    endtask

    task automatic test_store();
        int n;
        tick();
        dm_ce = 1'b1; dm_wr = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h12345678;
        sb.push_back('{1'b1, 32'd0});
        @(negedge clk);
        for (int c = 1; c <= Wait; c++) begin
            @(negedge clk);
            checks++;
            if (ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 32'h40 ||
                ram_wdata !== 32'h12345678) begin
                errors++;
                $display("FAIL store_access c%0d: ce=%b we=%b addr=%h wd=%h, expected 1 1 00000040 12345678",
                         c, ram_ce, ram_we, ram_addr, ram_wdata);
            end
        end
        @(negedge clk);
        checks++;
        if (dm_ready !== 1'b1 || ram_ce !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL store_done: dm_ready=%b ce=%b we=%b, expected 1 0 0", dm_ready, ram_ce, ram_we);
        end
        ref_mem[32'h40] = 32'h12345678;
        tick();
        dm_ce = 1'b0; dm_wr = 1'b0;
        @(negedge clk);
        checks++;
        if (dm_ready !== 1'b0) begin
            errors++;
            $display("FAIL store_single_pulse: dm_ready=%b after done, expected 0", dm_ready);
        end
        // Read the stored word back.
        tick();
        dm_ce = 1'b1; dm_addr = 32'h40;
        sb.push_back('{1'b1, ref_read(32'h40)});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dm_ready && n < 20);
        checks++;
        if (!dm_ready || n != Wait + 2) begin
            errors++;
            $display("FAIL readback_latency: ready=%b after %0d cycles, expected 1 after %0d",
                     dm_ready, n, Wait + 2);
        end
        tick();
        dm_ce = 1'b0;
    endtask

    task automatic test_tie();
        int dn, fn, rise;
        logic prev_ce, d_done, f_done;
        rst = 1'b1;
        dm_ce = 1'b1; dm_wr = 1'b0; dm_addr = 32'h300;
        if_ce = 1'b1; if_addr = 32'h400;
        sb.push_back('{1'b1, ref_read(32'h300)});
        sb.push_back('{1'b0, ref_read(32'h400)});
        sb.push_back('{1'b1, ref_read(32'h304)});
        sb.push_back('{1'b0, ref_read(32'h404)});
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        dn = 0; fn = 0; rise = -100; prev_ce = 1'b0;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            if (ram_ce && !prev_ce) rise = c;
            prev_ce = ram_ce;
            d_done = dm_ready;
            f_done = if_ready;
            if (d_done || f_done) begin
                checks++;
                if (c - rise != Wait) begin
                    errors++;
                    $display("FAIL tie_latency: ready %0d cycles after first ram_ce, expected %0d",
                             c - rise, Wait);
                end
                if (d_done) dn++;
                if (f_done) fn++;
            end
            tick();
            if (d_done) begin
                if (dn < 2) dm_addr = 32'h304;
                else dm_ce = 1'b0;
            end
            if (f_done) begin
                if (fn < 2) if_addr = 32'h404;
                else if_ce = 1'b0;
            end
        end
        checks++;
        if (dn != 2 || fn != 2) begin
            errors++;
            $display("FAIL tie_counts: data=%0d fetch=%0d completions, expected 2 2", dn, fn);
        end
    endtask

    task automatic test_llsc();
        int n;
        tick();
        dm_ce = 1'b1; dm_wr = 1'b0; dm_addr = 32'h80;
        sb.push_back('{1'b1, ref_read(32'h80)});
        @(negedge clk);
        @(negedge clk);
        wbit = 1'b1; wLLbit = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dm_ready && n < 20);
        checks++;
        if (!dm_ready || rLLbit !== 1'b0) begin
            errors++;
            $display("FAIL ll_no_early_commit: dm_ready=%b rLLbit=%b, expected 1 0", dm_ready, rLLbit);
        end
        tick();
        dm_ce = 1'b0; wbit = 1'b0;
        checks++;
        if (rLLbit !== 1'b1) begin
            errors++;
            $display("FAIL ll_set: rLLbit=%b, expected 1", rLLbit);
        end
        wbit = 1'b1; wLLbit = 1'b0;
        tick();
        checks++;
        if (rLLbit !== 1'b0) begin
            errors++;
            $display("FAIL sc_clear: rLLbit=%b, expected 0", rLLbit);
        end
        wLLbit = 1'b1;
        tick();
        checks++;
        if (rLLbit !== 1'b1) begin
            errors++;
            $display("FAIL ll_reset_by_wbit: rLLbit=%b, expected 1", rLLbit);
        end
        flush = 1'b1;
        tick();
        checks++;
        if (rLLbit !== 1'b0) begin
            errors++;
            $display("FAIL flush_priority: rLLbit=%b, expected 0", rLLbit);
        end
        flush = 1'b0; wbit = 1'b0; wLLbit = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        int n;
        tick();
        wbit = 1'b1; wLLbit = 1'b1;
        tick();
        wbit = 1'b0; wLLbit = 1'b0;
        dm_ce = 1'b1; dm_wr = 1'b1; dm_addr = 32'h60; dm_wdata = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ram_ce !== 1'b1 || ram_we !== 1'b1 || rLLbit !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: ce=%b we=%b ll=%b in second access cycle, expected 1 1 1",
                     ram_ce, ram_we, rLLbit);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ram_ce !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: ce=%b we=%b right after rst, expected 0 0", ram_ce, ram_we);
        end
        dm_ce = 1'b0; dm_wr = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if ({ram_ce, ram_we, if_ready, dm_ready, rLLbit} !== 5'b0 || ram_addr !== 32'd0 ||
            ram_wdata !== 32'd0 || if_data !== 32'd0 || dm_rdata !== 32'd0) begin
            errors++;
            $display("FAIL rst_release: ce=%b we=%b ll=%b addr=%h wd=%h ifd=%h dmd=%h, expected all 0",
                     ram_ce, ram_we, rLLbit, ram_addr, ram_wdata, if_data, dm_rdata);
        end
        tick();
        if_ce = 1'b1; if_addr = 32'h100;
        sb.push_back('{1'b0, 32'hDEADBEEF});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_ready && n < 20);
        checks++;
        if (!if_ready || n != Wait + 2) begin
            errors++;
            $display("FAIL rst_new_request: ready=%b after %0d cycles, expected 1 after %0d",
                     if_ready, n, Wait + 2);
        end
        tick();
        if_ce = 1'b0;
    endtask

    task automatic test_wait1();
        int got, ce_cycles, rise, last_ready;
        logic prev_ce, done;
        exp_t e;
        tick();
        w1_if_ce = 1'b1; w1_if_addr = 32'h200;
        sb1.push_back('{1'b0, base_val(32'h200)});
        got = 0; ce_cycles = 0; rise = -100; last_ready = -1; prev_ce = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (w1_ram_ce) ce_cycles++;
            if (w1_ram_ce && !prev_ce) rise = c;
            prev_ce = w1_ram_ce;
            done = w1_if_ready;
            if (done) begin
                e = sb1.pop_front();
                checks++;
                if (w1_if_data !== e.data || c - rise != 1 || w1_ram_we !== 1'b0) begin
                    errors++;
                    $display("FAIL w1_read: data=%h lat=%0d we=%b, expected %h 1 0",
                             w1_if_data, c - rise, w1_ram_we, e.data);
                end
                got++;
                last_ready = c;
            end
            tick();
            if (done) begin
                if (got < 3) begin
                    w1_if_addr = 32'h200 + 32'(4 * got);
                    sb1.push_back('{1'b0, base_val(w1_if_addr)});
                end else begin
                    w1_if_ce = 1'b0;
                end
            end
        end
        checks++;
        if (got != 3 || ce_cycles != 3 || last_ready != 8 || w1_dm_ready !== 1'b0) begin
            errors++;
            $display("FAIL w1_throughput: got=%0d ce_cycles=%0d last_ready=%0d dm_ready=%b, expected 3 3 8 0",
                     got, ce_cycles, last_ready, w1_dm_ready);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_tie();
        test_llsc();
        test_reset_mid_access();
        test_wait1();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0 || sb1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d and %0d completions outstanding, expected 0 0",
                     sb.size(), sb1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
